i2c_slave_rx_sequencer: RTL and testbench
=========================================

I2C_SLAVE_RX_SEQUENCER -- requirements
Module: i2c_slave_rx_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h50: 7-bit own address.
REQ-002 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have ports scl, sda, input, 1 each: I2C bus lines, already synchronised to clock.
REQ-005 SHALL have port sda_drive_low, output, 1: 1 = pull sda low (ACK); 0 = release.
REQ-006 SHALL have port rd_enable, output, 1: one-cycle start pulse to the byte reader.
REQ-007 SHALL have ports rd_data, rd_load, rd_finish, rd_error, input, 1 each: bit value, bit strobe, byte-done strobe and bit error from the byte reader.
REQ-008 SHALL have ports data_out, output, 8; data_valid, output, 1; data_ready, input, 1: received-byte valid/ready handshake.
REQ-009 SHALL have ports addressed, output, 1 (transaction active for this slave), overrun, output, 1 (sticky), bus_error, output, 1 (sticky).

Function
REQ-010 SHALL detect START as sda 1->0 and STOP as sda 0->1, each with scl high in both the previous and current samples.
REQ-011 SHALL implement states IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-012 SHALL go from any state to ADDR on START, including repeated START; addressed clears; shift register and bit count clear.
REQ-013 SHALL go from any state to IDLE on STOP; a partial byte is discarded with no data_valid pulse.
REQ-014 SHALL pulse rd_enable for exactly one cycle on the first scl rising edge in ADDR or DATA, and never again until that byte's rd_finish.
REQ-015 SHALL shift rd_data into the LSB on each rd_load, MSB first; the byte is complete on the rd_finish cycle, including that cycle's bit.
REQ-016 SHALL, in ADDR on rd_finish, decode byte[7:1] == SLAVE_ADDR with byte[0] == 0 (write) as a match: enter ADDR_ACK and set addressed.
REQ-017 SHALL, in ADDR on rd_finish, treat a mismatch or byte[0] == 1 (read unsupported) as no match: enter IGNORE, no ACK.
REQ-018 SHALL, in ADDR_ACK and DATA_ACK, assert sda_drive_low from the next scl falling edge until the following scl falling edge, then release it in that same cycle and enter DATA.
REQ-019 SHALL, in DATA on rd_finish with data_valid low, load data_out, set data_valid the next cycle and enter DATA_ACK.
REQ-020 SHALL, in DATA on rd_finish with data_valid still high, keep data_out, set overrun, not ACK that byte and enter IGNORE.
REQ-021 SHALL clear data_valid on the cycle after data_valid && data_ready; data_out SHALL stay stable while data_valid is high.
REQ-022 SHALL, on rd_error in ADDR or DATA, set bus_error, release sda and enter IGNORE.
REQ-023 SHALL, in IGNORE, keep sda released and issue no rd_enable until START or STOP.
REQ-024 SHALL give START/STOP priority over rd_finish or rd_error in the same cycle.

Reset
REQ-025 SHALL, while reset is high, set state IDLE and drive sda_drive_low=0, rd_enable=0, data_out=8'h00, data_valid=0, addressed=0, overrun=0, bus_error=0, and clear the edge history to 1.
REQ-026 SHALL, on reset mid-transfer, release sda in the first reset cycle and take no action until the next START.
REQ-027 SHALL clear overrun and bus_error only by reset.

Configuration
REQ-028 SHALL, with I2C_SLAVE_GENERAL_CALL_EN defined, also match address byte 8'h00 as a write and ACK it like REQ-016.
REQ-029 SHALL, without I2C_SLAVE_GENERAL_CALL_EN, treat 8'h00 as a mismatch and enter IGNORE.

Structure
REQ-030 SHALL place the state encoding, I2C_ADDR_W=7 and I2C_GENERAL_CALL=8'h00 in shared package i2c_pkg.
REQ-031 SHALL place START/STOP and scl-edge detection in sub-module i2c_bus_monitor, outputs start, stop, scl_rise, scl_fall.

Verification
REQ-032 SHALL check: START, byte 8'hA0 (0x50, write), bytes 8'h12, 8'h34 with data_ready=1, STOP -> three ACKs; data_out 8'h12 then 8'h34, one data_valid each; addressed falls at STOP.
REQ-033 SHALL check: START, byte 8'hA2 -> no ACK, IGNORE, no rd_enable until the next START.
REQ-034 SHALL check: START, 8'hA0, 8'h11, 8'h22 with data_ready=0 -> 8'h11 ACKed and held; 8'h22 NACKed; overrun=1.
REQ-035 SHALL check: START, 8'hA0, 4 data bits, repeated START, 8'hA0 -> no data_valid for the partial byte; the new address is ACKed.
REQ-036 SHALL check: START, byte 8'h00 -> ACK only when I2C_SLAVE_GENERAL_CALL_EN is defined, else no ACK.
REQ-037 SHALL check: rd_error during a data byte -> bus_error=1, sda released; reset mid-ACK -> sda_drive_low=0 in the first reset cycle.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave receive path: FSM encoding, address
// constants and the address-match helper.
package i2c_pkg;

  localparam int unsigned I2C_ADDR_W = 7;
  localparam logic [7:0]  I2C_GENERAL_CALL = 8'h00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  // Write to our own address, or a general call when that is enabled.
  function automatic logic addr_match(input logic [7:0]            b,
                                      input logic [I2C_ADDR_W-1:0] own,
                                      input logic                  gc_en);
    return ((b[7:1] == own) && !b[0]) || (gc_en && (b == I2C_GENERAL_CALL));
  endfunction

endpackage

// File: rtl/i2c_bus_monitor.sv
// START/STOP and scl edge detection on already-synchronised bus lines.
module i2c_bus_monitor (
  input  logic clock,
  input  logic reset,
  input  logic scl,
  input  logic sda,
  output logic start,
  output logic stop,
  output logic scl_rise,
  output logic scl_fall
);

  logic r_scl_prev;
  logic r_sda_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scl_prev <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      r_scl_prev <= scl;
      r_sda_prev <= sda;
    end
  end

  // sda may only change meaningfully while scl is high in both samples.
  assign start    = r_scl_prev && scl && r_sda_prev && !sda;
  assign stop     = r_scl_prev && scl && !r_sda_prev && sda;
  assign scl_rise = !r_scl_prev && scl;
  assign scl_fall = r_scl_prev && !scl;

endmodule

// File: rtl/i2c_slave_rx_sequencer.sv
// I2C slave write-only receive sequencer: address decode, ACK, byte handoff.
// Define I2C_SLAVE_GENERAL_CALL_EN to also accept the general-call address.
module i2c_slave_rx_sequencer
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_drive_low,
  output logic       rd_enable,
  input  logic       rd_data,
  input  logic       rd_load,
  input  logic       rd_finish,
  input  logic       rd_error,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       addressed,
  output logic       overrun,
  output logic       bus_error
);

`ifdef I2C_SLAVE_GENERAL_CALL_EN
  localparam logic GC_EN = 1'b1;
`else
  localparam logic GC_EN = 1'b0;
`endif

  logic       w_start;
  logic       w_stop;
  logic       w_scl_rise;
  logic       w_scl_fall;
  logic [7:0] w_byte;

  i2c_state_t r_state;
  logic [7:0] r_shift;
  logic       r_busy;
  logic       r_ack_on;
  logic       r_sda_low;
  logic       r_rd_enable;
  logic [7:0] r_data_out;
  logic       r_data_valid;
  logic       r_addressed;
  logic       r_overrun;
  logic       r_bus_error;

  i2c_bus_monitor u_mon (
    .clock    (clock),
    .reset    (reset),
    .scl      (scl),
    .sda      (sda),
    .start    (w_start),
    .stop     (w_stop),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall)
  );

  // The final bit arrives together with rd_finish.
  assign w_byte = rd_load ? {r_shift[6:0], rd_data} : r_shift;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_busy       <= 1'b0;
      r_ack_on     <= 1'b0;
      r_sda_low    <= 1'b0;
      r_rd_enable  <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_addressed  <= 1'b0;
      r_overrun    <= 1'b0;
      r_bus_error  <= 1'b0;
    end else begin
      r_rd_enable <= 1'b0;
      if (r_data_valid && data_ready)
        r_data_valid <= 1'b0;
      if (rd_load)
        r_shift <= {r_shift[6:0], rd_data};

      if (w_start || w_stop) begin
        r_state     <= w_start ? ST_ADDR : ST_IDLE;
        r_addressed <= 1'b0;
        r_shift     <= '0;
        r_busy      <= 1'b0;
        r_ack_on    <= 1'b0;
        r_sda_low   <= 1'b0;
      end else begin
        case (r_state)
          ST_ADDR, ST_DATA: begin
            if (w_scl_rise && !r_busy) begin
              r_rd_enable <= 1'b1;
              r_busy      <= 1'b1;
            end
            if (rd_error) begin
              r_bus_error <= 1'b1;
              r_sda_low   <= 1'b0;
              r_busy      <= 1'b0;
              r_rd_enable <= 1'b0;
              r_state     <= ST_IGNORE;
            end else if (rd_finish) begin
              r_busy <= 1'b0;
              if (r_state == ST_ADDR) begin
                if (addr_match(w_byte, SLAVE_ADDR, GC_EN)) begin
                  r_addressed <= 1'b1;
                  r_state     <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end else if (!r_data_valid) begin
                r_data_out   <= w_byte;
                r_data_valid <= 1'b1;
                r_state      <= ST_DATA_ACK;
              end else begin
                r_overrun <= 1'b1;
                r_state   <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK, ST_DATA_ACK: begin
            // First fall opens the ACK slot, the second one closes it.
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_low <= 1'b1;
                r_ack_on  <= 1'b1;
              end else begin
                r_sda_low <= 1'b0;
                r_ack_on  <= 1'b0;
                r_state   <= ST_DATA;
              end
            end
          end
          default: begin
            r_sda_low <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sda_drive_low = r_sda_low;
  assign rd_enable     = r_rd_enable;
  assign data_out      = r_data_out;
  assign data_valid    = r_data_valid;
  assign addressed     = r_addressed;
  assign overrun       = r_overrun;
  assign bus_error     = r_bus_error;

endmodule

// File: tb/tb_i2c_slave_rx_sequencer.sv
// Directed bench for i2c_slave_rx_sequencer; the bench plays master and byte reader.
module tb_i2c_slave_rx_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda = 1'b1;
  logic       sda_drive_low;
  logic       rd_enable;
  logic       rd_data = 1'b0;
  logic       rd_load = 1'b0;
  logic       rd_finish = 1'b0;
  logic       rd_error = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready = 1'b1;
  logic       addressed;
  logic       overrun;
  logic       bus_error;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned rd_en_cnt = 0;
  int unsigned dv_rise = 0;
  logic        dv_q = 1'b0;
  logic [7:0]  acc[$];

  i2c_slave_rx_sequencer #(.SLAVE_ADDR(7'h50)) dut (
    .clock         (clock),
    .reset         (reset),
    .scl           (scl),
    .sda           (sda),
    .sda_drive_low (sda_drive_low),
    .rd_enable     (rd_enable),
    .rd_data       (rd_data),
    .rd_load       (rd_load),
    .rd_finish     (rd_finish),
    .rd_error      (rd_error),
    .data_out      (data_out),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .addressed     (addressed),
    .overrun       (overrun),
    .bus_error     (bus_error)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (rd_enable) rd_en_cnt <= rd_en_cnt + 1;
    if (data_valid && !dv_q) dv_rise <= dv_rise + 1;
    if (data_valid && data_ready) acc.push_back(data_out);
    dv_q <= data_valid;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; scl = 1'b1; sda = 1'b1;
    rd_load = 1'b0; rd_finish = 1'b0; rd_error = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic bus_start();
    scl = 1'b0; tick(1);
    sda = 1'b1; tick(1);
    scl = 1'b1; tick(2);
    sda = 1'b0; tick(2);
    scl = 1'b0; tick(1);
  endtask

  task automatic bus_stop();
    scl = 1'b0; tick(1);
    sda = 1'b0; tick(1);
    scl = 1'b1; tick(2);
    sda = 1'b1; tick(2);
  endtask

  // One scl clock; optionally strobes the reader outputs while scl is high.
  task automatic clock_bit(input logic b, input logic ld, input logic fin, output logic ack);
    scl = 1'b0; tick(1);
    sda = b;    tick(1);
    scl = 1'b1; tick(1);
    if (ld) begin
      rd_data = b; rd_load = 1'b1; rd_finish = fin;
    end
    tick(1);
    rd_load = 1'b0; rd_finish = 1'b0;
    ack = sda_drive_low;
    tick(1);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ld, output logic ack);
    logic dummy;
    for (int i = 7; i >= 0; i--)
      clock_bit(v[i], ld, (i == 0), dummy);
    clock_bit(1'b1, 1'b0, 1'b0, ack);
  endtask

  initial begin
    logic ack;
    logic dummy;
    int unsigned c;
    logic [7:0] partial;

    do_reset();
    check("rst_sda",   sda_drive_low, 0);
    check("rst_rden",  rd_enable, 0);
    check("rst_dout",  data_out, 8'h00);
    check("rst_dv",    data_valid, 0);
    check("rst_addr",  addressed, 0);
    check("rst_ovr",   overrun, 0);
    check("rst_berr",  bus_error, 0);

    // Addressed write of two bytes, consumer always ready
    data_ready = 1'b1;
    acc.delete();
    c = rd_en_cnt;
    bus_start();
    send_byte(8'hA0, 1'b1, ack); check("w_addr_ack", ack, 1);
    check("w_addressed", addressed, 1);
    send_byte(8'h12, 1'b1, ack); check("w_d0_ack", ack, 1);
    send_byte(8'h34, 1'b1, ack); check("w_d1_ack", ack, 1);
    check("w_rden_cnt", rd_en_cnt - c, 3);
    check("w_acc_n", acc.size(), 2);
    if (acc.size() == 2) begin
      check("w_acc0", acc[0], 8'h12);
      check("w_acc1", acc[1], 8'h34);
    end
    check("w_dv_rise", dv_rise, 2);
    check("w_dout", data_out, 8'h34);
    bus_stop();
    check("w_stop_addr", addressed, 0);

    // Wrong address: NACK, then the reader stays idle
    do_reset();
    bus_start();
    send_byte(8'hA2, 1'b1, ack); check("m_nack", ack, 0);
    check("m_addressed", addressed, 0);
    c = rd_en_cnt;
    send_byte(8'h55, 1'b0, ack); check("m_ign_ack", ack, 0);
    check("m_ign_rden", rd_en_cnt - c, 0);
    bus_start();
    clock_bit(1'b1, 1'b0, 1'b0, dummy);
    check("m_restart_rden", rd_en_cnt - c, 1);
    bus_stop();

    // Consumer stalled: second byte overruns
    do_reset();
    data_ready = 1'b0;
    acc.delete();
    bus_start();
    send_byte(8'hA0, 1'b1, ack); check("o_addr_ack", ack, 1);
    send_byte(8'h11, 1'b1, ack); check("o_d0_ack", ack, 1);
    send_byte(8'h22, 1'b1, ack); check("o_d1_nack", ack, 0);
    check("o_overrun", overrun, 1);
    check("o_dout", data_out, 8'h11);
    check("o_dv", data_valid, 1);
    bus_stop();
    data_ready = 1'b1;
    tick(2);
    check("o_dv_clr", data_valid, 0);
    check("o_acc", acc.size(), 1);
    check("o_ovr_sticky", overrun, 1);

    // Partial byte cut by repeated START
    do_reset();
    c = dv_rise;
    bus_start();
    send_byte(8'hA0, 1'b1, ack); check("r_addr_ack", ack, 1);
    partial = 8'hB0;
    for (int i = 7; i >= 4; i--)
      clock_bit(partial[i], 1'b1, 1'b0, dummy);
    bus_start();
    check("r_addr_clr", addressed, 0);
    send_byte(8'hA0, 1'b1, ack); check("r_readdr_ack", ack, 1);
    check("r_no_dv", dv_rise - c, 0);
    bus_stop();

    // General-call address
    do_reset();
    bus_start();
    send_byte(8'h00, 1'b1, ack);
`ifdef I2C_SLAVE_GENERAL_CALL_EN
    check("gc_ack", ack, 1);
`else
    check("gc_nack", ack, 0);
`endif
    bus_stop();

    // Reader error during a data byte
    do_reset();
    bus_start();
    send_byte(8'hA0, 1'b1, ack); check("e_addr_ack", ack, 1);
    partial = 8'hC5;
    for (int i = 7; i >= 5; i--)
      clock_bit(partial[i], 1'b1, 1'b0, dummy);
    rd_error = 1'b1; tick(1);
    rd_error = 1'b0; tick(1);
    check("e_berr", bus_error, 1);
    check("e_sda", sda_drive_low, 0);
    for (int i = 4; i >= 0; i--)
      clock_bit(partial[i], 1'b0, 1'b0, dummy);
    clock_bit(1'b1, 1'b0, 1'b0, ack); check("e_nack", ack, 0);
    bus_stop();
    check("e_berr_sticky", bus_error, 1);

    // Reset while the ACK is being driven
    bus_start();
    partial = 8'hA0;
    for (int i = 7; i >= 0; i--)
      clock_bit(partial[i], 1'b1, (i == 0), dummy);
    scl = 1'b0; tick(2);
    check("ra_ack_on", sda_drive_low, 1);
    reset = 1'b1; tick(1);
    check("ra_sda_rel", sda_drive_low, 0);
    check("ra_berr_clr", bus_error, 0);
    reset = 1'b0; scl = 1'b1; tick(2);
    check("ra_idle_sda", sda_drive_low, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
